data_mem_dma: RTL and testbench

//  Initiator-side engine for the single-port data_mem: drives DataAddress/ReadMem/

---
 rtl/data_mem_dma_if.sv | 20 ++
 rtl/data_mem_dma.sv | 109 ++++++++++
 tb/tb_data_mem_dma.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_dma_if.sv
// Memory-port bundle between the DMA engine (master) and the single-port data_mem (slave).
interface data_mem_dma_if #(
    parameter int AW = 8
);
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/data_mem_dma.sv
// Block COPY / FILL engine for data_mem; every output is a register loaded with the
// value it must carry in the state being entered.
module data_mem_dma #(
    parameter int AW = 8,
    parameter int LW = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [AW-1:0]        src_addr,
    input  logic [AW-1:0]        dst_addr,
    input  logic [LW-1:0]        len,
    input  logic [7:0]           fill_val,
    output logic                 busy,
    output logic                 done,
    output logic [LW-1:0]        count,
    data_mem_dma_if.master       mem
);

    typedef enum logic [2:0] {IDLE, RD, WR, FILL, DONE} state_t;

    state_t        state;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [LW-1:0] remaining;
    logic [7:0]    fill_reg;

    // mem_wdata doubles as the byte buffer: loaded from mem_rdata on leaving RD, it
    // holds the copied byte for exactly the WR cycle and is zero elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            src_ptr       <= '0;
            dst_ptr       <= '0;
            remaining     <= '0;
            fill_reg      <= '0;
            count         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_rd    <= 1'b0;
            mem.mem_wr    <= 1'b0;
            mem.mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= len;
                        fill_reg  <= fill_val;
                        count     <= '0;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (!mode) begin
                            state        <= RD;
                            busy         <= 1'b1;
                            mem.mem_rd   <= 1'b1;
                            mem.mem_addr <= src_addr;
                        end else begin
                            state         <= FILL;
                            busy          <= 1'b1;
                            mem.mem_wr    <= 1'b1;
                            mem.mem_addr  <= dst_addr;
                            mem.mem_wdata <= fill_val;
                        end
                    end
                end
                RD: begin
                    src_ptr       <= src_ptr + 1'b1;
                    state         <= WR;
                    mem.mem_rd    <= 1'b0;
                    mem.mem_wr    <= 1'b1;
                    mem.mem_addr  <= dst_ptr;
                    mem.mem_wdata <= mem.mem_rdata;
                end
                WR, FILL: begin
                    dst_ptr   <= dst_ptr + 1'b1;
                    count     <= count + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == LW'(1)) begin
                        state         <= DONE;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        mem.mem_rd    <= 1'b0;
                        mem.mem_wr    <= 1'b0;
                        mem.mem_addr  <= '0;
                        mem.mem_wdata <= '0;
                    end else if (state == WR) begin
                        state         <= RD;
                        mem.mem_wr    <= 1'b0;
                        mem.mem_rd    <= 1'b1;
                        mem.mem_addr  <= src_ptr;
                        mem.mem_wdata <= '0;
                    end else begin
                        mem.mem_addr  <= dst_ptr + 1'b1;
                        mem.mem_wdata <= fill_reg;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_dma.sv
// Scoreboard bench for data_mem_dma: stimulus pushes hand-computed reads, writes and
// done events; a negedge monitor pops and compares them as the DUT presents them.
module tb_data_mem_dma;
    localparam int AW = 8;
    localparam int LW = 9;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] cnt;
    } done_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [7:0]    src_addr = '0;
    logic [7:0]    dst_addr = '0;
    logic [8:0]    len = '0;
    logic [7:0]    fill_val = '0;
    logic          busy;
    logic          done;
    logic [8:0]    count;

    data_mem_dma_if #(.AW(AW)) mem_bus ();

    data_mem_dma #(.AW(AW), .LW(LW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .fill_val (fill_val),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .mem      (mem_bus)
    );

    always #5 clk = ~clk;

    // Behavioural data_mem plus a bench-side preload port
    logic [7:0] tb_mem [256];
    logic       pre_we = 1'b0;
    logic [7:0] pre_addr = '0;
    logic [7:0] pre_data = '0;

    always @(posedge clk) begin
        if (mem_bus.mem_wr) tb_mem[mem_bus.mem_addr] <= mem_bus.mem_wdata;
        else if (pre_we)    tb_mem[pre_addr] <= pre_data;
    end

    assign mem_bus.mem_rdata = mem_bus.mem_rd ? tb_mem[mem_bus.mem_addr] : 8'h00;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned busy_lo = 1;
    int unsigned busy_hi = 0;

    logic [7:0]  rd_q [$];
    logic [15:0] wr_q [$];
    done_t       done_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        check("busy", {31'd0, busy}, {31'd0, (cyc >= busy_lo && cyc <= busy_hi)});
        check("rd_wr_excl", {31'd0, mem_bus.mem_rd & mem_bus.mem_wr}, 32'd0);
        if (!busy)
            check("idle_bus", {14'd0, mem_bus.mem_rd, mem_bus.mem_wr, mem_bus.mem_addr,
                               mem_bus.mem_wdata}, 32'd0);
        if (mem_bus.mem_rd) begin
            if (rd_q.size() == 0) check("unexpected_rd", {24'd0, mem_bus.mem_addr}, 32'hFFFF_FFFF);
            else check("rd_addr", {24'd0, mem_bus.mem_addr}, {24'd0, rd_q.pop_front()});
        end
        if (mem_bus.mem_wr) begin
            if (wr_q.size() == 0)
                check("unexpected_wr", {16'd0, mem_bus.mem_addr, mem_bus.mem_wdata}, 32'hFFFF_FFFF);
            else
                check("wr_addr_data", {16'd0, mem_bus.mem_addr, mem_bus.mem_wdata},
                      {16'd0, wr_q.pop_front()});
        end
        if (done) begin
            if (done_q.size() == 0) check("unexpected_done", cyc, 32'hFFFF_FFFF);
            else begin
                done_t e;
                e = done_q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("done_count", {23'd0, count}, e.cnt);
            end
        end
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic pulse_start(input logic m, input logic [7:0] s, input logic [7:0] d,
                               input logic [8:0] n, input logic [7:0] v);
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = n; fill_val = v;
        @(posedge clk); #1;
        start = 1'b0; mode = ~m; src_addr = ~s; dst_addr = d ^ 8'h5A; len = ~n; fill_val = ~v;
    endtask

    // Accepted op: busy expected in cycles t0+1..t0+blen, done pushed at t0+dlat
    task automatic issue(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [8:0] n, input logic [7:0] v, input int unsigned blen,
                         input int unsigned dlat, input int unsigned cnt, input bit push_done);
        int unsigned t0;
        t0 = cyc;
        busy_lo = t0 + 1;
        busy_hi = t0 + blen;
        if (push_done) done_q.push_back('{cyc: t0 + dlat, cnt: cnt});
        pulse_start(m, s, d, n, v);
    endtask

    task automatic check_mem(input logic [7:0] a, input logic [7:0] exp);
        check($sformatf("mem[%02h]", a), {24'd0, tb_mem[a]}, {24'd0, exp});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_count", {23'd0, count}, 32'd0);
        check("rst_bus", {14'd0, mem_bus.mem_rd, mem_bus.mem_wr, mem_bus.mem_addr,
                          mem_bus.mem_wdata}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // COPY 0x10->0x80 len 4, with ignored starts in cycle 3 and in the DONE cycle
        poke(8'h10, 8'h11); poke(8'h11, 8'h22); poke(8'h12, 8'h33); poke(8'h13, 8'h44);
        poke(8'h84, 8'hEE); poke(8'h40, 8'h5A);
        rd_q.push_back(8'h10); rd_q.push_back(8'h11); rd_q.push_back(8'h12); rd_q.push_back(8'h13);
        wr_q.push_back(16'h8011); wr_q.push_back(16'h8122);
        wr_q.push_back(16'h8233); wr_q.push_back(16'h8344);
        issue(1'b0, 8'h10, 8'h80, 9'd4, 8'h00, 8, 9, 4, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        pulse_start(1'b1, 8'h00, 8'h40, 9'd2, 8'h77);
        repeat (5) @(posedge clk);
        #1;
        pulse_start(1'b1, 8'h00, 8'h40, 9'd2, 8'h77);
        repeat (2) @(posedge clk);
        #1;
        check_mem(8'h80, 8'h11); check_mem(8'h81, 8'h22);
        check_mem(8'h82, 8'h33); check_mem(8'h83, 8'h44);
        check_mem(8'h84, 8'hEE); check_mem(8'h40, 8'h5A);

        // FILL 0x20 len 3 with 0xA5
        poke(8'h23, 8'h3C);
        wr_q.push_back(16'h20A5); wr_q.push_back(16'h21A5); wr_q.push_back(16'h22A5);
        issue(1'b1, 8'h00, 8'h20, 9'd3, 8'hA5, 3, 4, 3, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check_mem(8'h20, 8'hA5); check_mem(8'h22, 8'hA5); check_mem(8'h23, 8'h3C);

        // COPY wrapping source 0xFE..0x01 -> 0x7E..0x81
        poke(8'hFE, 8'h01); poke(8'hFF, 8'h02); poke(8'h00, 8'h03); poke(8'h01, 8'h04);
        rd_q.push_back(8'hFE); rd_q.push_back(8'hFF); rd_q.push_back(8'h00); rd_q.push_back(8'h01);
        wr_q.push_back(16'h7E01); wr_q.push_back(16'h7F02);
        wr_q.push_back(16'h8003); wr_q.push_back(16'h8104);
        issue(1'b0, 8'hFE, 8'h7E, 9'd4, 8'h00, 8, 9, 4, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check_mem(8'h7E, 8'h01); check_mem(8'h81, 8'h04);

        // FILL wrapping destination 0xFF, 0x00
        wr_q.push_back(16'hFF6B); wr_q.push_back(16'h006B);
        issue(1'b1, 8'h00, 8'hFF, 9'd2, 8'h6B, 2, 3, 2, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_mem(8'hFF, 8'h6B); check_mem(8'h00, 8'h6B); check_mem(8'h01, 8'h04);

        // len = 0: done in cycle 1, no access
        issue(1'b0, 8'h05, 8'h06, 9'd0, 8'h00, 0, 1, 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Overlapping COPY dst = src+1 replicates M[0x30]
        poke(8'h30, 8'h09); poke(8'h31, 8'hF1); poke(8'h32, 8'hF2); poke(8'h33, 8'hF3);
        rd_q.push_back(8'h30); rd_q.push_back(8'h31); rd_q.push_back(8'h32);
        wr_q.push_back(16'h3109); wr_q.push_back(16'h3209); wr_q.push_back(16'h3309);
        issue(1'b0, 8'h30, 8'h31, 9'd3, 8'h00, 6, 7, 3, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check_mem(8'h33, 8'h09);

        // Reset after two copied bytes aborts at once
        poke(8'h90, 8'hD0); poke(8'h91, 8'hD1); poke(8'h92, 8'hD2); poke(8'h93, 8'hD3);
        rd_q.push_back(8'h10); rd_q.push_back(8'h11);
        wr_q.push_back(16'h9011); wr_q.push_back(16'h9122);
        issue(1'b0, 8'h10, 8'h90, 9'd4, 8'h00, 4, 0, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_bus", {14'd0, mem_bus.mem_rd, mem_bus.mem_wr, mem_bus.mem_addr,
                            mem_bus.mem_wdata}, 32'd0);
        check("abort_count", {23'd0, count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_mem(8'h90, 8'h11); check_mem(8'h91, 8'h22);
        check_mem(8'h92, 8'hD2); check_mem(8'h93, 8'hD3);

        // Full-memory FILL, len = 256
        for (int i = 0; i < 256; i++) wr_q.push_back({i[7:0], 8'hC3});
        issue(1'b1, 8'h00, 8'h00, 9'd256, 8'hC3, 256, 257, 256, 1'b1);
        repeat (260) @(posedge clk);
        #1;
        check_mem(8'h00, 8'hC3); check_mem(8'h80, 8'hC3); check_mem(8'hFF, 8'hC3);
        check("count_hold", {23'd0, count}, 32'd256);

        check("rd_q_left", rd_q.size(), 32'd0);
        check("wr_q_left", wr_q.size(), 32'd0);
        check("done_q_left", done_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
